// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_stream slice.
//   DEMUX_N_CH / DEMUX_DATA_W / DEMUX_CNT_W : default build parameters
//   DEMUX_MAX_CH / DEMUX_SEL_MAX            : upper bound on channel count and select width
//   onehot(sel, n)                          : one-hot vector with bit sel set, or all zero when sel >= n
package demux_pkg;

   localparam int DEMUX_N_CH    = 8;
   localparam int DEMUX_DATA_W  = 8;
   localparam int DEMUX_CNT_W   = 16;

   localparam int DEMUX_MAX_CH  = 64;
   localparam int DEMUX_SEL_MAX = 6;

   // Returned vector is DEMUX_MAX_CH wide; callers keep only the low N_CH bits.
   function automatic logic [DEMUX_MAX_CH-1:0] onehot(input logic [DEMUX_SEL_MAX-1:0] sel,
                                                      input int unsigned n);
      logic [DEMUX_MAX_CH-1:0] v;
      v = '0;
      if (32'(sel) < n)
         v[sel] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/demux_if.sv
// Stream and counter bundle between one producer and N_CH consumers.
//   in_data/in_sel/in_valid/in_ready : upstream valid/ready beat with destination channel
//   out_data/out_valid/out_ready     : shared payload bus, one-hot valid, per-channel ready
//   sel_err                          : pulse for a discarded out-of-range beat
//   cnt_clr/cnt_flat                 : channel counter clear and packed counter readout
// Modports: master = producer/consumer side (testbench), slave = demux_stream.
interface demux_if
   import demux_pkg::*;
#(
   parameter int N_CH   = DEMUX_N_CH,
   parameter int DATA_W = DEMUX_DATA_W,
   parameter int CNT_W  = DEMUX_CNT_W
) ();
   localparam int SEL_W = $clog2(N_CH);

   logic [DATA_W-1:0]     in_data;
   logic [SEL_W-1:0]      in_sel;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     out_data;
   logic [N_CH-1:0]       out_valid;
   logic [N_CH-1:0]       out_ready;
   logic                  sel_err;
   logic                  cnt_clr;
   logic [N_CH*CNT_W-1:0] cnt_flat;

   modport master (
      output in_data, in_sel, in_valid, out_ready, cnt_clr,
      input  in_ready, out_data, out_valid, sel_err, cnt_flat
   );

   modport slave (
      input  in_data, in_sel, in_valid, out_ready, cnt_clr,
      output in_ready, out_data, out_valid, sel_err, cnt_flat
   );

endinterface

// File: rtl/demux_sat_cnt.sv
// Saturating up-counter for one demux channel.
//   clk, reset : clock, async active-high reset
//   inc        : count one drained beat
//   clr        : synchronous clear, wins over inc
//   cnt        : current count, holds at all-ones
module demux_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/demux_stream.sv
// One-stage registered 1:N_CH stream demultiplexer with backpressure.
//   clk, reset : clock, async active-high reset (drops any held beat)
//   bus        : demux_if.slave -- input stream, shared out_data, one-hot out_valid,
//                per-channel out_ready, sel_err pulse, cnt_clr / cnt_flat
// Build option: DEMUX_CNT_EN adds a saturating drain counter per channel;
// without it cnt_flat reads zero and cnt_clr is ignored.
module demux_stream
   import demux_pkg::*;
#(
   parameter int N_CH   = DEMUX_N_CH,
   parameter int DATA_W = DEMUX_DATA_W,
   parameter int CNT_W  = DEMUX_CNT_W
) (
   input  logic   clk,
   input  logic   reset,
   demux_if.slave bus
);
   localparam int SEL_W = $clog2(N_CH);

   logic                     full;
   logic [SEL_W-1:0]         sel_q;
   logic [DATA_W-1:0]        data_q;
   logic                     sel_err_q;
   logic [DEMUX_SEL_MAX-1:0] sel_wide;
   logic [N_CH-1:0]          valid_c;
   logic                     drain;
   logic                     accept;
   logic                     legal;
   logic [N_CH*CNT_W-1:0]    cnt_flat;

   assign sel_wide = DEMUX_SEL_MAX'(sel_q);

   always_comb begin
      valid_c = '0;
      for (int k = 0; k < N_CH; k++)
         valid_c[k] = full && (((onehot(sel_wide, N_CH) >> k) & DEMUX_MAX_CH'(1)) != '0);
   end

   // Masking with the one-hot vector ignores ready on every non-selected channel.
   assign drain  = |(valid_c & bus.out_ready);
   assign accept = bus.in_valid && bus.in_ready;
   assign legal  = (int'(bus.in_sel) < N_CH);

   assign bus.in_ready  = !full || drain;
   assign bus.out_valid = valid_c;
   assign bus.out_data  = data_q;
   assign bus.sel_err   = sel_err_q;
   assign bus.cnt_flat  = cnt_flat;

   // An out-of-range beat is consumed but never loaded, so the held beat
   // (if any) simply follows its own drain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full      <= 1'b0;
         sel_q     <= '0;
         data_q    <= '0;
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= accept && !legal;
         if (accept && legal) begin
            full   <= 1'b1;
            sel_q  <= bus.in_sel;
            data_q <= bus.in_data;
         end else if (drain) begin
            full <= 1'b0;
         end
      end
   end

`ifdef DEMUX_CNT_EN
   for (genvar k = 0; k < N_CH; k++) begin : g_cnt
      demux_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .reset (reset),
         .inc   (drain && valid_c[k]),
         .clr   (bus.cnt_clr),
         .cnt   (cnt_flat[k*CNT_W +: CNT_W])
      );
   end
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = bus.cnt_clr;
   assign cnt_flat       = '0;
`endif

endmodule
